myo_spi_responder: RTL and testbench

MYO_SPI_RESPONDER -- requirements
Module: myo_spi_responder

---
 rtl/myo_spi_pkg.sv | 9 +
 rtl/myo_spi_sync.sv | 18 +
 rtl/myo_spi_responder.sv | 115 +++++++++++
 tb/tb_myo_spi_responder.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/myo_spi_pkg.sv
// myo_spi_pkg: shared FSM type, default sizes and index-width helper for the SPI responder
package myo_spi_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam int WORD_W      = 16;
    localparam int FRAME_WORDS = 12;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/myo_spi_sync.sv
// myo_spi_sync: N-flop input synchronizer with a selectable reset value
// Ports: clk/reset_n clock and async active-low reset; d async input; q synchronized output
module myo_spi_sync #(
    parameter int   N       = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);
    logic [N-1:0] ff;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ff <= {N{RST_VAL}};
        else          ff <= N'({ff, d});
    end
    assign q = ff[N-1];
endmodule

// File: rtl/myo_spi_responder.sv
// myo_spi_responder: SPI mode-0 frame responder with a TX word bank and an RX word stream
// Ports: clk/reset_n system clock and async active-low reset; sck/ss_n/mosi/miso/miso_oe SPI bus;
//        tx_wr/tx_addr/tx_wdata bank writes; rx_valid/rx_data/rx_index received words;
//        frame_done/frame_err frame-end pulses; overrun sticky overflow flag, overrun_clr clears it
module myo_spi_responder #(
    parameter int WORD_W      = myo_spi_pkg::WORD_W,
    parameter int FRAME_WORDS = myo_spi_pkg::FRAME_WORDS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                                        clk,
    input  logic                                        reset_n,
    input  logic                                        sck,
    input  logic                                        ss_n,
    input  logic                                        mosi,
    output logic                                        miso,
    output logic                                        miso_oe,
    input  logic                                        tx_wr,
    input  logic [myo_spi_pkg::idx_w(FRAME_WORDS)-1:0]  tx_addr,
    input  logic [WORD_W-1:0]                           tx_wdata,
    output logic                                        rx_valid,
    output logic [WORD_W-1:0]                           rx_data,
    output logic [myo_spi_pkg::idx_w(FRAME_WORDS)-1:0]  rx_index,
    output logic                                        frame_done,
    output logic                                        frame_err,
    output logic                                        overrun,
    input  logic                                        overrun_clr
);
    import myo_spi_pkg::*;
    localparam int IW = idx_w(FRAME_WORDS);
    localparam int CW = idx_w(FRAME_WORDS + 1);
    localparam int BW = idx_w(WORD_W);
    state_t            state, state_d;
    logic              sck_s, ss_s, mosi_s, sck_q, ss_q, ss_pend;
    logic              sck_rise, sck_fall, ss_rise, ss_fall, start, last, keep;
    logic [BW-1:0]     bit_cnt;
    logic [CW-1:0]     word_cnt;
    logic [WORD_W-1:0] tx_sh, load_val;
    logic [WORD_W-2:0] rx_sh;
    logic [WORD_W-1:0] bank [FRAME_WORDS];

    myo_spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck  (.clk, .reset_n, .d(sck),  .q(sck_s));
    myo_spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss   (.clk, .reset_n, .d(ss_n), .q(ss_s));
    myo_spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (.clk, .reset_n, .d(mosi), .q(mosi_s));

    // SCK edges only count while select is asserted
    assign sck_rise = sck_s & ~sck_q & ~ss_s;
    assign sck_fall = ~sck_s & sck_q & ~ss_s;
    assign ss_rise  = ss_s & ~ss_q;
    assign ss_fall  = ~ss_s & ss_q;

    always_comb begin
        start      = (state == IDLE) && (ss_fall || ss_pend);
        state_d    = start ? SHIFT : (state == SHIFT && ss_rise) ? DONE : (state == DONE) ? IDLE : state;
        last       = bit_cnt == BW'(WORD_W - 1);
        keep       = int'(word_cnt) < FRAME_WORDS;
        load_val   = keep ? bank[word_cnt[IW-1:0]] : '0;
        miso_oe    = state == SHIFT;
        miso       = miso_oe ? tx_sh[WORD_W-1] : 1'b1;
        frame_done = (state == DONE) && (bit_cnt == '0);
        frame_err  = (state == DONE) && (bit_cnt != '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FRAME_WORDS; i++) bank[i] <= '0;
        end else if (tx_wr && int'(tx_addr) < FRAME_WORDS) begin
            bank[tx_addr] <= tx_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            sck_q    <= 1'b0;
            ss_q     <= 1'b1;
            ss_pend  <= 1'b0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            rx_index <= '0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_d;
            sck_q    <= sck_s;
            ss_q     <= ss_s;
            // a select edge seen during DONE starts the frame on the following IDLE cycle
            ss_pend  <= (state == DONE) && ss_fall;
            rx_valid <= 1'b0;
            if (start) begin
                bit_cnt  <= '0;
                word_cnt <= '0;
                tx_sh    <= bank[0];
            end else if (state == SHIFT) begin
                // bit_cnt is zero on a falling edge only right after a completed word
                if (sck_fall) tx_sh <= (bit_cnt == '0) ? load_val : {tx_sh[WORD_W-2:0], 1'b0};
                if (sck_rise) begin
                    rx_sh   <= (WORD_W-1)'({rx_sh, mosi_s});
                    bit_cnt <= last ? '0 : bit_cnt + BW'(1);
                    if (last) begin
                        word_cnt <= keep ? word_cnt + CW'(1) : word_cnt;
                        rx_valid <= keep;
                        if (keep) begin
                            rx_data  <= {rx_sh, mosi_s};
                            rx_index <= word_cnt[IW-1:0];
                        end
                    end
                end
            end
            overrun <= overrun_clr ? 1'b0 : (overrun || (state == SHIFT && sck_rise && last && !keep));
        end
    end
endmodule

// File: tb/tb_myo_spi_responder.sv
// tb_myo_spi_responder: directed and randomized frames against a word-level model of the responder
module tb_myo_spi_responder;
    localparam int FW = 12;
    logic        clk = 1'b0, reset_n = 1'b0;
    logic        sck = 1'b0, ss_n = 1'b1, mosi = 1'b0, miso, miso_oe;
    logic        tx_wr = 1'b0;
    logic [3:0]  tx_addr = '0;
    logic [15:0] tx_wdata = '0;
    logic        rx_valid, frame_done, frame_err, overrun, overrun_clr = 1'b0;
    logic [15:0] rx_data;
    logic [3:0]  rx_index;

    int          n_cmp = 0, n_bad = 0, n_done = 0, n_err = 0, exp_done = 0, exp_err = 0, chk_ptr = 0;
    logic [31:0] rxq[$], exp_rx[$];
    logic [15:0] bank_m [FW];
    logic [15:0] mw;
    logic        m;

    myo_spi_responder dut (
        .clk(clk), .reset_n(reset_n), .sck(sck), .ss_n(ss_n), .mosi(mosi), .miso(miso),
        .miso_oe(miso_oe), .tx_wr(tx_wr), .tx_addr(tx_addr), .tx_wdata(tx_wdata),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_index(rx_index), .frame_done(frame_done),
        .frame_err(frame_err), .overrun(overrun), .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) rxq.push_back({12'h0, rx_index, rx_data});
        if (frame_done) n_done++;
        if (frame_err) n_err++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tx_write(input logic [3:0] a, input logic [15:0] d);
        tx_addr  = a;
        tx_wdata = d;
        tx_wr    = 1'b1;
        @(negedge clk);
        tx_wr = 1'b0;
        if (a < FW) bank_m[a] = d;
    endtask

    task automatic xfer_bit(input logic b, output logic mo);
        mosi = b;
        repeat (5) @(negedge clk);
        mo  = miso;
        sck = 1'b1;
        repeat (5) @(negedge clk);
        sck = 1'b0;
    endtask

    // nw full words, then part extra bits (part>0 ends the frame mid-word); optional bank write
    // at bit 8 of word wr_w; gap = clocks with select high after the frame
    task automatic run_frame(input int nw, input int part, input int wr_w, input logic [3:0] wr_a,
                             input logic [15:0] wr_d, input bit fixed, input int gap);
        logic [15:0] w_out, got, exp;
        logic        b;
        int          bits;
        ss_n = 1'b0;
        repeat (5) @(negedge clk);
        check("miso_oe_active", 32'(miso_oe), 32'd1);
        for (int w = 0; w < nw + (part > 0 ? 1 : 0); w++) begin
            exp   = (w < FW) ? bank_m[w] : 16'h0000;
            w_out = fixed ? 16'hA5A5 : 16'($urandom);
            bits  = (w < nw) ? 16 : part;
            got   = '0;
            for (int i = 0; i < bits; i++) begin
                if (w == wr_w && i == 8) tx_write(wr_a, wr_d);
                xfer_bit(w_out[15-i], b);
                got[15-i] = b;
            end
            if (bits == 16) begin
                check($sformatf("miso_word%0d", w), 32'(got), 32'(exp));
                if (w < FW) exp_rx.push_back({12'h0, 4'(w), w_out});
            end
        end
        repeat (3) @(negedge clk);
        ss_n = 1'b1;
        if (part > 0) exp_err++;
        else exp_done++;
        repeat (gap) @(negedge clk);
    endtask

    task automatic check_all();
        repeat (10) @(negedge clk);
        check("rx_count", rxq.size(), exp_rx.size());
        for (int k = chk_ptr; k < rxq.size() && k < exp_rx.size(); k++)
            check($sformatf("rx_word%0d", k), rxq[k], exp_rx[k]);
        chk_ptr = exp_rx.size();
        check("frame_done_count", n_done, exp_done);
        check("frame_err_count", n_err, exp_err);
        check("idle_bus", {30'h0, miso_oe, miso}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < FW; i++) bank_m[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_miso", 32'(miso), 32'd1);
        check("rst_miso_oe", 32'(miso_oe), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < FW; i++) tx_write(4'(i), 16'h1000 + 16'(i));
        tx_write(4'd13, 16'hDEAD);
        run_frame(12, 0, -1, 4'd0, 16'h0, 1'b1, 5);
        check_all();

        run_frame(3, 7, -1, 4'd0, 16'h0, 1'b0, 5);
        check_all();

        for (int i = 0; i < FW; i++) tx_write(4'(i), 16'($urandom));
        run_frame(14, 0, -1, 4'd0, 16'h0, 1'b0, 5);
        check_all();
        check("overrun_set", 32'(overrun), 32'd1);

        run_frame(3, 0, 1, 4'd2, 16'hBEEF, 1'b0, 5);
        check_all();
        run_frame(3, 0, 2, 4'd2, 16'h1234, 1'b0, 5);
        check_all();
        check("overrun_held", 32'(overrun), 32'd1);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        @(negedge clk);
        check("overrun_cleared", 32'(overrun), 32'd0);

        run_frame(4, 0, -1, 4'd0, 16'h0, 1'b0, 3);
        run_frame(4, 0, -1, 4'd0, 16'h0, 1'b0, 5);
        check_all();

        ss_n = 1'b0;
        repeat (5) @(negedge clk);
        for (int w = 0; w < 5; w++) begin
            mw = 16'($urandom);
            for (int i = 0; i < 16; i++) xfer_bit(mw[15-i], m);
            exp_rx.push_back({12'h0, 4'(w), mw});
        end
        for (int i = 0; i < 8; i++) xfer_bit(1'b1, m);
        reset_n = 1'b0;
        #1;
        check("arst_miso", 32'(miso), 32'd1);
        check("arst_miso_oe", 32'(miso_oe), 32'd0);
        check("arst_rx_valid", 32'(rx_valid), 32'd0);
        check("arst_rx_data", 32'(rx_data), 32'd0);
        check("arst_rx_index", 32'(rx_index), 32'd0);
        check("arst_done_err", {30'h0, frame_done, frame_err}, 32'd0);
        check("arst_overrun", 32'(overrun), 32'd0);
        ss_n = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < FW; i++) bank_m[i] = '0;
        check_all();
        run_frame(2, 0, -1, 4'd0, 16'h0, 1'b0, 5);
        check_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
